// File: rtl/tdc_pkg.sv
// Shared types for the TDC event builder: FSM state, event-word layout, timeout word.
// Timeout feature is selected in the top by `define TDC_EVB_TIMEOUT_EN.
package tdc_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } evb_state_t;

    // Default geometry; the top re-derives widths from its own parameters.
    localparam int DEF_FINE_W   = 5;
    localparam int DEF_COARSE_W = 4;
    localparam int DEF_TS_W     = DEF_FINE_W + DEF_COARSE_W;

    typedef struct packed {
        logic                timeout;
        logic [DEF_TS_W-1:0] interval;
    } evt_word_t;

    localparam evt_word_t TIMEOUT_WORD = '{timeout: 1'b1, interval: '1};

endpackage

// File: rtl/tdc_event_fifo.sv
// Synchronous FIFO for event words; a push while full is accepted only if a pop
// happens in the same cycle. out_data reads zero when empty.
module tdc_event_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          push, pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // full implies non-empty, so out_ready alone guarantees a slot frees up
    assign in_ready  = !full || out_ready;
    assign push      = in_valid && in_ready;
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_data;
    end

endmodule

// File: rtl/tdc_event_builder.sv
// Start/stop TDC event builder: measures stop-start intervals into an event FIFO.
// Define TDC_EVB_TIMEOUT_EN to add the ARMED timeout that emits {1, all-ones}.
module tdc_event_builder
    import tdc_pkg::*;
#(
    parameter int FINE_W      = 5,
    parameter int COARSE_W    = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_valid,
    input  logic [FINE_W-1:0]          start_fine,
    input  logic [COARSE_W-1:0]        start_coarse,
    input  logic                       stop_valid,
    input  logic [FINE_W-1:0]          stop_fine,
    input  logic [COARSE_W-1:0]        stop_coarse,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COARSE_W+FINE_W:0]   out_data,
    output logic [7:0]                 drop_cnt,
    output logic                       armed
);
    localparam int W = COARSE_W + FINE_W;

    evb_state_t  state;
    logic [W-1:0] start_ts_q, start_ts, stop_ts, interval;
    logic         stop_hit, push, push_ok;
    logic [W:0]   push_data;
    logic         fifo_full, fifo_empty;
    logic         unused_fifo_flags;

    assign start_ts = {start_coarse, start_fine};
    assign stop_ts  = {stop_coarse, stop_fine};
    assign interval = stop_ts - start_ts_q;   // modular wrap is the intended result
    assign stop_hit = (state == ST_ARMED) && stop_valid;
    assign armed    = (state == ST_ARMED);

`ifdef TDC_EVB_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       timeout_hit;

    // A stop wins over timeout; a fresh start restarts the window instead.
    assign timeout_hit = (state == ST_ARMED) && !stop_valid && !start_valid &&
                         (tcnt == 8'(TIMEOUT_CYC - 1));
    assign push        = stop_hit || timeout_hit;
    assign push_data   = stop_hit ? {1'b0, interval} : {1'b1, {W{1'b1}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                tcnt <= '0;
        else if (start_valid || state != ST_ARMED) tcnt <= '0;
        else if (!timeout_hit)                     tcnt <= tcnt + 1'b1;
        else                                       tcnt <= '0;
    end
`else
    assign push      = stop_hit;
    assign push_data = {1'b0, interval};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            start_ts_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        state      <= ST_ARMED;
                        start_ts_q <= start_ts;
                    end
                end
                default: begin
                    if (start_valid)   start_ts_q <= start_ts;
                    else if (push)     state      <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    drop_cnt <= '0;
        else if (push && !push_ok && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end

    tdc_event_fifo #(
        .DW    (W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push),
        .in_ready  (push_ok),
        .in_data   (push_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign unused_fifo_flags = fifo_full ^ fifo_empty;

endmodule

// File: tb/tb_tdc_event_builder.sv
// Scoreboarded directed test of tdc_event_builder (default geometry, 9-bit timestamps).
module tb_tdc_event_builder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid, stop_valid, out_ready;
    logic [4:0] start_fine, stop_fine;
    logic [3:0] start_coarse, stop_coarse;
    logic       out_valid, armed;
    logic [9:0] out_data;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    tdc_event_builder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_fine   (start_fine),
        .start_coarse (start_coarse),
        .stop_valid   (stop_valid),
        .stop_fine    (stop_fine),
        .stop_coarse  (stop_coarse),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .drop_cnt     (drop_cnt),
        .armed        (armed)
    );

    // Monitor: every accepted word is popped against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %h required none", out_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL sb_word[%0d]: got %h required %h", n_pop, out_data, e);
                end
            end
            n_pop++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic sv, input logic [3:0] sc, input logic [4:0] sf,
                          input logic pv, input logic [3:0] pc, input logic [4:0] pf);
        start_valid = sv; start_coarse = sc; start_fine = sf;
        stop_valid  = pv; stop_coarse  = pc; stop_fine  = pf;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        stop_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        start_valid = 1'b0; start_fine = '0; start_coarse = '0;
        stop_valid  = 1'b0; stop_fine  = '0; stop_coarse  = '0;
        cyc(2);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_drop_cnt",  32'(drop_cnt),  0);
        chk("rst_armed",     32'(armed),     0);
        rst_n = 1'b1;
        cyc(1);

        // Basic interval, stop six cycles after start: 0x082 - 0x065
        exp_q.push_back(10'h01D);
        strobe(1, 4'h3, 5'h05, 0, 0, 0);
        chk("armed_after_start", 32'(armed), 1);
        cyc(5);
        strobe(0, 0, 0, 1, 4'h4, 5'h02);
        chk("latency_out_valid", 32'(out_valid), 1);
        chk("basic_out_data", 32'(out_data), 32'h01D);
        chk("idle_after_stop", 32'(armed), 0);
        cyc(2);

        // Wrap: 0x010 - 0x1F0 mod 512
        exp_q.push_back(10'h020);
        strobe(1, 4'hF, 5'h10, 0, 0, 0);
        cyc(2);
        strobe(0, 0, 0, 1, 4'h0, 5'h10);
        cyc(2);

        // Stop in IDLE ignored; both strobes in IDLE arm and ignore the stop
        strobe(0, 0, 0, 1, 4'h2, 5'h03);
        cyc(2);
        chk("idle_stop_ignored", 32'(out_valid), 0);
        strobe(1, 4'h0, 5'h04, 1, 4'h5, 5'h05);
        chk("idle_both_armed", 32'(armed), 1);
        chk("idle_both_no_evt", 32'(out_valid), 0);
        exp_q.push_back(10'h005);
        strobe(0, 0, 0, 1, 4'h0, 5'h09);
        cyc(2);

        // Start-only in ARMED relatches: 0x008 - 0x003
        exp_q.push_back(10'h005);
        strobe(1, 4'h0, 5'h01, 0, 0, 0);
        strobe(1, 4'h0, 5'h03, 0, 0, 0);
        strobe(0, 0, 0, 1, 4'h0, 5'h08);
        cyc(2);

        // Simultaneous start/stop in ARMED: event vs old start, new start kept
        exp_q.push_back(10'h020);
        exp_q.push_back(10'h040);
        strobe(1, 4'h1, 5'h00, 0, 0, 0);
        strobe(1, 4'h1, 5'h00, 1, 4'h2, 5'h00);
        chk("both_armed_stays", 32'(armed), 1);
        strobe(0, 0, 0, 1, 4'h3, 5'h00);
        cyc(2);

        // Backpressure: five events into a 4-deep FIFO, the fifth is dropped
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(10'(i));
            strobe(1, 4'h0, 5'h00, 0, 0, 0);
            strobe(0, 0, 0, 1, 4'h0, 5'(i));
        end
        chk("bp_drop_cnt", 32'(drop_cnt), 1);
        chk("bp_first_word", 32'(out_data), 1);
        cyc(3);
        chk("bp_word_stable", 32'(out_data), 1);
        chk("bp_out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        cyc(6);
        chk("bp_drained", 32'(out_valid), 0);

`ifdef TDC_EVB_TIMEOUT_EN
        exp_q.push_back(10'h3FF);
        strobe(1, 4'h0, 5'h00, 0, 0, 0);
        cyc(14);
        chk("to_armed_before", 32'(armed), 1);
        cyc(1);
        chk("to_armed_after", 32'(armed), 0);
        chk("to_out_valid", 32'(out_valid), 1);
        chk("to_out_data", 32'(out_data), 32'h3FF);
        cyc(2);
`else
        strobe(1, 4'h0, 5'h00, 0, 0, 0);
        cyc(20);
        chk("no_to_armed", 32'(armed), 1);
        exp_q.push_back(10'h000);
        strobe(0, 0, 0, 1, 4'h0, 5'h00);
        cyc(2);
`endif

        // Reset while ARMED with two words queued: everything discarded
        out_ready = 1'b0;
        for (int i = 3; i <= 4; i++) begin
            strobe(1, 4'h0, 5'h00, 0, 0, 0);
            strobe(0, 0, 0, 1, 4'h0, 5'(i));
        end
        strobe(1, 4'h0, 5'h00, 0, 0, 0);
        chk("pre_rst_valid", 32'(out_valid), 1);
        chk("pre_rst_armed", 32'(armed), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_data",  32'(out_data),  0);
        chk("mid_rst_armed",     32'(armed),     0);
        chk("mid_rst_drop_cnt",  32'(drop_cnt),  0);
        cyc(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        strobe(0, 0, 0, 1, 4'h0, 5'h07);
        cyc(3);
        chk("post_rst_no_evt", 32'(out_valid), 0);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tdc_event_builder.md
TDC_EVENT_BUILDER -- requirements
Module: tdc_event_builder

Interface
REQ-001 SHALL have parameter FINE_W, default 5, meaning fine-bin width from the thermometer encoder.
REQ-002 SHALL have parameter COARSE_W, default 4, meaning coarse-counter width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning event buffer entries (power of 2, >=2).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 15, meaning ARMED cycles allowed before timeout (1..255).
REQ-005 SHALL have ports as listed below; one clock; reset is asynchronous and active-low.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  one-cycle strobe: start timestamp present.
- start_fine  in  FINE_W  fine bin of start.
- start_coarse  in  COARSE_W  coarse count of start.
- stop_valid  in  1  one-cycle strobe: stop timestamp present.
- stop_fine  in  FINE_W  fine bin of stop.
- stop_coarse  in  COARSE_W  coarse count of stop.
- out_valid  out  1  event word available.
- out_ready  in  1  consumer accepts word.
- out_data  out  W+1  {timeout_flag, interval}, W = COARSE_W+FINE_W.
- drop_cnt  out  8  saturating count of events lost to a full FIFO.
- armed  out  1  high while in ARMED.

Function
REQ-006 SHALL form timestamp ts = {coarse, fine}, W bits.
REQ-007 SHALL compute interval = (stop_ts - start_ts) mod 2^W; wrap-around yields the modular result, e.g. start 0x1F0, stop 0x010 -> 0x020.
REQ-008 SHALL implement FSM IDLE/ARMED: IDLE + start_valid -> ARMED, start_ts latched; stop_valid in IDLE ignored.
REQ-009 SHALL, in ARMED with stop_valid, push an event with timeout_flag=0 and return to IDLE.
REQ-010 SHALL, in ARMED with start_valid only, relatch start_ts, restart the timeout counter and stay ARMED.
REQ-011 SHALL, in ARMED with start_valid and stop_valid together, push the event for the old start, latch the new start_ts and stay ARMED.
REQ-012 SHALL, in IDLE with both strobes together, enter ARMED with start_ts latched and ignore the stop.
REQ-013 SHALL write the event into the FIFO at the edge sampling stop_valid; out_valid SHALL be high in the following cycle (latency 1).
REQ-014 SHALL transfer a word when out_valid and out_ready are both high; out_data SHALL hold stable while out_valid is high and out_ready is low.
REQ-015 SHALL accept a push when full if a pop occurs in the same cycle; otherwise SHALL drop the event and increment drop_cnt, saturating at 255.
REQ-016 SHALL keep FIFO order; an empty FIFO SHALL give out_valid=0.

Reset
REQ-017 SHALL, with rst_n low, immediately force: FSM IDLE, FIFO empty, out_valid=0, out_data=0, drop_cnt=0, armed=0, timeout counter=0.
REQ-018 SHALL discard any ARMED measurement on reset mid-operation; no event is emitted for it.

Configuration
REQ-019 SHALL compile the timeout feature in with macro TDC_EVB_TIMEOUT_EN.
- Defined: after TIMEOUT_CYC consecutive ARMED cycles without stop, push {1, all-ones} and go IDLE. A stop arriving in that same cycle wins, giving a normal event.
- Undefined: ARMED waits indefinitely; timeout_flag is constant 0; no counter logic.

Structure
REQ-020 SHALL place the FSM state enum, the event-word typedef and the all-ones timeout constant in shared package tdc_pkg.
REQ-021 SHALL implement buffering as sub-module tdc_event_fifo, a synchronous FIFO with full, empty and valid/ready ports.

Verification
REQ-022 SHALL cover: start {3,5}, stop {4,2} after 6 cycles, out_ready=1 -> out_data={0,0x01D}, one cycle after the stop.
REQ-023 SHALL cover: start {0xF,0x10}, stop {0x0,0x10} -> interval 0x020 (wrap).
REQ-024 SHALL cover: out_ready=0, 5 start/stop pairs with DEPTH 4 -> 4 words held, drop_cnt=1, first word unchanged.
REQ-025 SHALL cover: with TDC_EVB_TIMEOUT_EN, start and no stop for 15 cycles -> out_data={1,0x1FF}, armed=0; without the macro, armed stays 1.
REQ-026 SHALL cover: rst_n low while ARMED with 2 words queued -> out_valid=0 at once and no event after release.
REQ-027 SHALL cover: in ARMED, simultaneous start {1,0} and stop {2,0} -> event 0x020 relative to the old start, armed stays 1.
